// File: rtl/axi_pkg.sv
// axi_pkg: AXI burst/response encodings and the latched request type
package axi_pkg;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_ID_W = 8;
  typedef enum logic [1:0] {BURST_FIXED = 2'b00, BURST_INCR = 2'b01, BURST_WRAP = 2'b10} burst_e;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } req_t;
  function automatic logic req_illegal(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst, input logic [2:0] lsb);
    return size > lsb || burst == 2'b11 ||
           (burst == BURST_WRAP && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
endpackage

// File: rtl/axi_burst_addr.sv
// axi_burst_addr: next beat address for FIXED, INCR and WRAP bursts
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [7:0]        i_len,
  input  logic [2:0]        i_size,
  input  logic [1:0]        i_burst,
  output logic [ADDR_W-1:0] o_next_addr
);
  logic [ADDR_W-1:0] w_inc, w_mask;
  assign w_inc = i_addr + (ADDR_W'(1) << i_size);
  // wrap window is (len+1) beats of 2^size bytes, aligned to its own size
  assign w_mask = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);
  assign o_next_addr = i_burst == BURST_FIXED ? i_addr :
                       i_burst == BURST_WRAP  ? (i_addr & ~w_mask) | (w_inc & w_mask) : w_inc;
endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave serialising reads and writes onto one SRAM port
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int ID_W   = AXI_ID_W,
  parameter int DEPTH  = 16384
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [ID_W-1:0]     i_awid,
  input  logic [ADDR_W-1:0]   i_awaddr,
  input  logic [7:0]          i_awlen,
  input  logic [2:0]          i_awsize,
  input  logic [1:0]          i_awburst,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic                i_wlast,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic [ID_W-1:0]     o_bid,
  output logic [1:0]          o_bresp,
  output logic                o_bvalid,
  input  logic                i_bready,
  input  logic [ID_W-1:0]     i_arid,
  input  logic [ADDR_W-1:0]   i_araddr,
  input  logic [7:0]          i_arlen,
  input  logic [2:0]          i_arsize,
  input  logic [1:0]          i_arburst,
  input  logic                i_arvalid,
  output logic                o_arready,
  output logic [ID_W-1:0]     o_rid,
  output logic [DATA_W-1:0]   o_rdata,
  output logic [1:0]          o_rresp,
  output logic                o_rlast,
  output logic                o_rvalid,
  input  logic                i_rready
);
  localparam int LSB = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RD, WR, WR_RESP} state_e;
  state_e r_state;
  req_t r_req;
  logic r_started, r_last_wr, r_ill, r_werr, r_rvalid, r_rlast, r_bvalid;
  logic [7:0] r_cnt;
  logic [1:0] r_rresp, r_bresp;
  logic [ID_W-1:0] r_rid, r_bid;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic w_idle, w_both, w_ar_hs, w_aw_hs, w_w_hs, w_rd_err, w_wr_oor, w_wr_last, w_wlast_bad, w_mem_we;
  logic [ADDR_W-1:0] w_addr, w_next, w_rd_addr;
  logic [IDX_W-1:0] w_rd_idx, w_wr_idx;
  logic [DATA_W-1:0] w_rd_data;
  axi_burst_addr #(.ADDR_W(ADDR_W)) u_addr (
    .i_addr(w_addr), .i_len(r_req.len), .i_size(r_req.size), .i_burst(r_req.burst), .o_next_addr(w_next)
  );
  // readies stay low until the first edge after reset release
  assign w_idle = r_state == IDLE && r_started;
  assign w_both = i_awvalid && i_arvalid;
  assign o_arready = w_idle && !(w_both && !r_last_wr);
  assign o_awready = w_idle && !(w_both && r_last_wr);
  assign o_wready = r_state == WR;
  assign w_ar_hs = i_arvalid && o_arready;
  assign w_aw_hs = i_awvalid && o_awready;
  assign w_w_hs = i_wvalid && o_wready;
  assign w_addr = r_req.addr[ADDR_W-1:0];
  // a read is issued for the incoming request in IDLE, otherwise for the following beat
  assign w_rd_addr = r_state == IDLE ? i_araddr : w_next;
  assign w_rd_err = (r_state == IDLE ? req_illegal(i_arlen, i_arsize, i_arburst, 3'(LSB)) : r_ill) ||
                    |(w_rd_addr >> (IDX_W + LSB));
  assign w_rd_idx = w_rd_addr[IDX_W+LSB-1:LSB];
  assign w_rd_data = w_rd_err ? '0 : r_mem[w_rd_idx];
  assign w_wr_oor = |(w_addr >> (IDX_W + LSB));
  assign w_wr_idx = w_addr[IDX_W+LSB-1:LSB];
  assign w_wr_last = r_cnt == r_req.len;
  assign w_wlast_bad = i_wlast != w_wr_last;
  assign w_mem_we = w_w_hs && !w_wr_oor && !r_ill;
  assign o_rvalid = r_rvalid;
  assign o_rdata = r_rdata;
  assign o_rresp = r_rresp;
  assign o_rlast = r_rlast;
  assign o_rid = r_rid;
  assign o_bvalid = r_bvalid;
  assign o_bresp = r_bresp;
  assign o_bid = r_bid;
  always_ff @(posedge ACLK) begin
    if (w_mem_we)
      for (int b = 0; b < DATA_W / 8; b++)
        if (i_wstrb[b]) r_mem[w_wr_idx][8*b +: 8] <= i_wdata[8*b +: 8];
  end
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= IDLE;
      r_started <= 1'b0;
      r_last_wr <= 1'b1;
      r_req <= '0;
      r_cnt <= '0;
      r_ill <= 1'b0;
      r_werr <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
      r_rlast <= 1'b0;
      r_rid <= '0;
      r_bvalid <= 1'b0;
      r_bresp <= RESP_OKAY;
      r_bid <= '0;
    end else begin
      r_started <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_ar_hs) begin
            r_state <= RD;
            r_last_wr <= 1'b0;
            r_req <= '{id: AXI_ID_W'(i_arid), addr: AXI_ADDR_W'(i_araddr), len: i_arlen, size: i_arsize, burst: i_arburst};
            r_ill <= req_illegal(i_arlen, i_arsize, i_arburst, 3'(LSB));
            r_cnt <= '0;
            r_rvalid <= 1'b1;
            r_rid <= i_arid;
            r_rlast <= i_arlen == 8'd0;
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
          end else if (w_aw_hs) begin
            r_state <= WR;
            r_last_wr <= 1'b1;
            r_req <= '{id: AXI_ID_W'(i_awid), addr: AXI_ADDR_W'(i_awaddr), len: i_awlen, size: i_awsize, burst: i_awburst};
            r_ill <= req_illegal(i_awlen, i_awsize, i_awburst, 3'(LSB));
            r_werr <= 1'b0;
            r_cnt <= '0;
          end
        end
        RD: begin
          if (i_rready && r_rlast) begin
            r_state <= IDLE;
            r_rvalid <= 1'b0;
            r_rlast <= 1'b0;
          end else if (i_rready) begin
            r_req.addr <= AXI_ADDR_W'(w_next);
            r_cnt <= r_cnt + 8'd1;
            r_rlast <= r_cnt + 8'd1 == r_req.len;
            r_rdata <= w_rd_data;
            r_rresp <= w_rd_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
        WR: begin
          if (w_w_hs) begin
            r_werr <= r_werr || w_wr_oor || w_wlast_bad;
            r_req.addr <= AXI_ADDR_W'(w_next);
            r_cnt <= r_cnt + 8'd1;
            if (w_wr_last) begin
              r_state <= WR_RESP;
              r_bvalid <= 1'b1;
              r_bid <= r_req.id[ID_W-1:0];
              r_bresp <= (r_ill || r_werr || w_wr_oor || w_wlast_bad) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        WR_RESP: begin
          if (i_bready) begin
            r_state <= IDLE;
            r_bvalid <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
